// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and helpers for the streaming FFT stages.
package fft_pkg;
  localparam int FFT_DATA_WIDTH = 25;
  localparam int BF_GROWTH = 1;
  function automatic int bf_delay(input int fft_n, input int stage);
    return fft_n >> (stage + 1);
  endfunction
  function automatic int out_width(input int w);
    return w + BF_GROWTH;
  endfunction
  function automatic int stage_width(input int w0, input int stage);
    return w0 + stage * BF_GROWTH;
  endfunction
  function automatic int sel_bit(input int nlog2, input int stage);
    return nlog2 - 1 - stage;
  endfunction
endpackage

// File: rtl/fft_delay_line.sv
// fft_delay_line: fixed DEPTH-cycle delay, circular RAM buffer for deep lines, shift registers otherwise.
module fft_delay_line #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  if (DEPTH > 2) begin : g_ram
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;
    // Read and write share one address, so the word read is the one written DEPTH cycles ago
    assign dout = mem[ptr];
    always_ff @(posedge clk_i) mem[ptr] <= din;
    always_ff @(posedge clk_i) begin
      if (!rst_n) ptr <= '0;
      else ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];
    logic unused_rst;
    assign unused_rst = rst_n;
    assign dout = sr[DEPTH-1];
    always_ff @(posedge clk_i) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
endmodule

// File: rtl/fft_bf.sv
// fft_bf: radix-2 single-delay-feedback butterfly stage, one complex sample per clock.
module fft_bf
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int FFT_N      = 1024,
  parameter int NLOG2      = 10,
  parameter int STAGE      = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic        [NLOG2-1:0]      ctr_i,
  output logic        [NLOG2-1:0]      ctr_o,
  input  logic signed [DATA_WIDTH-1:0] x_re_i,
  input  logic signed [DATA_WIDTH-1:0] x_im_i,
  output logic signed [DATA_WIDTH:0]   z_re_o,
  output logic signed [DATA_WIDTH:0]   z_im_o
);
  localparam int OW = out_width(DATA_WIDTH);
  localparam int DELAY = bf_delay(FFT_N, STAGE);
  localparam int SB = sel_bit(NLOG2, STAGE);
  logic sel, primed;
  logic signed [OW-1:0] x_re, x_im, d_re, d_im, w_re, w_im, y_re, y_im;
  logic [2*OW-1:0] dl_q;
  assign sel = ctr_i[SB];
  assign x_re = {x_re_i[DATA_WIDTH-1], x_re_i};
  assign x_im = {x_im_i[DATA_WIDTH-1], x_im_i};
  assign d_re = dl_q[2*OW-1:OW];
  assign d_im = dl_q[OW-1:0];
  // First half parks x and drains last block's differences; second half emits sums and parks differences
  always_comb begin
    w_re = sel ? d_re - x_re : x_re;
    w_im = sel ? d_im - x_im : x_im;
    y_re = sel ? d_re + x_re : d_re;
    y_im = sel ? d_im + x_im : d_im;
  end
  fft_delay_line #(.WIDTH(2 * OW), .DEPTH(DELAY)) u_dl (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .din   ({w_re, w_im}),
    .dout  (dl_q)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      primed <= 1'b0;
      ctr_o  <= '0;
      z_re_o <= '0;
      z_im_o <= '0;
    end else begin
      primed <= primed | sel;
      ctr_o  <= ctr_i - NLOG2'(DELAY);
      z_re_o <= (primed | sel) ? y_re : '0;
      z_im_o <= (primed | sel) ? y_im : '0;
    end
  end
endmodule

// File: tb/tb_fft_bf.sv
// tb_fft_bf: random and directed checks of fft_bf against a sample-history butterfly model.
module tb_fft_bf;
  localparam int DW = 25;
  localparam int OW = 26;
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;
  logic [2:0] ctr_s;
  logic [9:0] ctr_b;
  logic signed [DW-1:0] x_re, x_im;
  logic signed [OW-1:0] zr_s [3], zi_s [3], zr_b [10], zi_b [10];
  logic [2:0] co_s [3];
  logic [9:0] co_b [10];
  genvar g;
  for (g = 0; g < 3; g++) begin : g_s
    fft_bf #(.DATA_WIDTH(DW), .FFT_N(8), .NLOG2(3), .STAGE(g)) u_dut (
      .clk_i(clk_i), .rst_n(rst_n), .ctr_i(ctr_s), .ctr_o(co_s[g]),
      .x_re_i(x_re), .x_im_i(x_im), .z_re_o(zr_s[g]), .z_im_o(zi_s[g]));
  end
  for (g = 0; g < 10; g++) begin : g_b
    fft_bf #(.DATA_WIDTH(DW), .FFT_N(1024), .NLOG2(10), .STAGE(g)) u_dut (
      .clk_i(clk_i), .rst_n(rst_n), .ctr_i(ctr_b), .ctr_o(co_b[g]),
      .x_re_i(x_re), .x_im_i(x_im), .z_re_o(zr_b[g]), .z_im_o(zi_b[g]));
  end
  int n_pass = 0, n_chk = 0, t = 0;
  int h_re [8192], h_im [8192];
  int ramp_z [12] = '{0, 0, 0, 0, 6, 8, 10, 12, -4, -4, -4, -4};
  int ramp_c [12] = '{4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
  int p_xr [9] = '{3, 1, 3, 1, -16777216, 16777215, -16777216, -16777216, 0};
  int p_xi [9] = '{2, -5, 2, -5, 0, 0, 0, 0, 0};
  int p_zr [9] = '{0, 4, 2, 4, 2, -1, -33554431, -33554432, 0};
  int p_zi [9] = '{0, -3, 7, -3, 7, 0, 0, 0, 0};
  int p_c  [9] = '{7, 0, 1, 2, 3, 4, 5, 6, 7};
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  // Output for the sample fed at time tt since reset: sum of pair (tt-d, tt) in the second
  // half of a block, difference of pair (tt-2d, tt-d) in the first half, zero before priming
  task automatic model(input int n, input int s, input int tt, output longint er, output longint ei, output longint ec);
    int d, c;
    d = n >> (s + 1);
    c = tt % n;
    ec = longint'((c - d + n) % n);
    if (tt < d) begin
      er = 0;
      ei = 0;
    end else if (((c / d) % 2) == 1) begin
      er = longint'(h_re[tt-d]) + longint'(h_re[tt]);
      ei = longint'(h_im[tt-d]) + longint'(h_im[tt]);
    end else begin
      er = longint'(h_re[tt-2*d]) - longint'(h_re[tt-d]);
      ei = longint'(h_im[tt-2*d]) - longint'(h_im[tt-d]);
    end
  endtask
  function automatic int rnd();
    logic signed [DW-1:0] v;
    v = DW'($urandom);
    return int'(v);
  endfunction
  task automatic step(input int xr, input int xi);
    longint er, ei, ec;
    ctr_s = 3'(t % 8);
    ctr_b = 10'(t % 1024);
    x_re = DW'(xr);
    x_im = DW'(xi);
    h_re[t] = xr;
    h_im[t] = xi;
    @(posedge clk_i);
    #1;
    for (int s = 0; s < 3; s++) begin
      model(8, s, t, er, ei, ec);
      chk($sformatf("n8_s%0d_re_t%0d", s, t), zr_s[s], er);
      chk($sformatf("n8_s%0d_im_t%0d", s, t), zi_s[s], ei);
      chk($sformatf("n8_s%0d_ctr_t%0d", s, t), co_s[s], ec);
    end
    for (int s = 0; s < 10; s++) begin
      model(1024, s, t, er, ei, ec);
      chk($sformatf("n1024_s%0d_re_t%0d", s, t), zr_b[s], er);
      chk($sformatf("n1024_s%0d_im_t%0d", s, t), zi_b[s], ei);
      chk($sformatf("n1024_s%0d_ctr_t%0d", s, t), co_b[s], ec);
    end
    t++;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    ctr_s = 3'($urandom);
    ctr_b = 10'($urandom);
    x_re = DW'($urandom);
    x_im = DW'($urandom);
    @(posedge clk_i);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_n8_s%0d_re", s), zr_s[s], 0);
      chk($sformatf("rst_n8_s%0d_im", s), zi_s[s], 0);
      chk($sformatf("rst_n8_s%0d_ctr", s), co_s[s], 0);
    end
    for (int s = 0; s < 10; s++) begin
      chk($sformatf("rst_n1024_s%0d_re", s), zr_b[s], 0);
      chk($sformatf("rst_n1024_s%0d_ctr", s), co_b[s], 0);
    end
    rst_n = 1'b1;
    t = 0;
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(i + 1, 0);
      chk($sformatf("ramp_re_%0d", i), zr_s[0], ramp_z[i]);
      chk($sformatf("ramp_ctr_%0d", i), co_s[0], ramp_c[i]);
    end
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(p_xr[i], p_xi[i]);
      chk($sformatf("pair_re_%0d", i), zr_s[2], p_zr[i]);
      chk($sformatf("pair_im_%0d", i), zi_s[2], p_zi[i]);
      chk($sformatf("pair_ctr_%0d", i), co_s[2], p_c[i]);
    end
    do_reset();
    for (int i = 0; i < 5; i++) step(rnd(), rnd());
    do_reset();
    for (int i = 0; i < 3 * 1024 + 16; i++) step(rnd(), rnd());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
